exe_stage: RTL and testbench

Execute stage of the 5-stage pipeline, placed directly downstream of the ID/EXE pipeline register and upstream of the EXE/MEM register. It consumes the decoded operands and control fields latched by ID/EXE and computes the ALU result. It resolves branches for the fetch stage. It runs a 32-cycle iterative unsigned divider, and while the divider is running it stalls the front of the pipeline and inserts bubbles into EXE/MEM.

---
 rtl/exe_pkg.sv | 44 ++++
 rtl/exe_stage_div_iter.sv | 123 ++++++++++++
 rtl/exe_stage.sv | 125 ++++++++++++
 tb/tb_exe_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute stage.
//   - exe_cmd_e     : ALU command encoding driven on exe_cmd
//   - branch_type_e : branch kind driven on branch_type
//   - div_state_e   : iterative divider FSM states
//   - DIV_CYCLES    : number of restoring-divide steps (one per quotient bit)
// -----------------------------------------------------------------------------
package exe_pkg;

    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned DIV_CNT_W  = $clog2(DIV_CYCLES);

    typedef enum logic [3:0] {
        CMD_ADD = 4'h0,
        CMD_SUB = 4'h1,
        CMD_AND = 4'h2,
        CMD_OR  = 4'h3,
        CMD_NOR = 4'h4,
        CMD_XOR = 4'h5,
        CMD_SLL = 4'h6,
        CMD_SRL = 4'h7,
        CMD_SRA = 4'h8,
        CMD_SLT = 4'h9,
        CMD_MUL = 4'hA,
        CMD_DIV = 4'hB,
        CMD_REM = 4'hC,
        CMD_NOP = 4'hF
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } branch_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/exe_stage_div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// 32-step restoring unsigned divider with its IDLE/BUSY/DONE control FSM.
// Only built when EXE_DIV_EN is defined (instantiated from exe_stage).
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   i_start      in   request a new division (sampled combinationally in IDLE)
//   i_dividend   in   32-bit unsigned dividend
//   i_divisor    in   32-bit unsigned divisor
//   o_busy       out  high in the start cycle and for every BUSY cycle
//   o_done       out  high for the single DONE cycle (results valid)
//   o_quotient   out  quotient register
//   o_remainder  out  remainder register
//
// Divide by zero needs no special case: every trial subtraction succeeds,
// so the quotient fills with ones and the dividend shifts into the remainder.
// -----------------------------------------------------------------------------
module div_iter
    import exe_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    div_state_e            r_state;
    div_state_e            w_next;
    logic [DIV_CNT_W-1:0]  r_count;
    logic [31:0]           r_quo;
    logic [31:0]           r_rem;
    logic [31:0]           r_divisor;
    logic                  w_start;
    logic                  w_load;
    logic                  w_step;
    logic [32:0]           w_shift;
    logic [32:0]           w_diff;

    // The start path is combinational; gating with reset keeps the stall low
    // while reset is held even if ID/EXE still presents a divide.
    assign w_start = i_start & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_load = 1'b1;
                    o_busy = 1'b1;
                    w_next = BUSY;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                o_busy = 1'b1;
                if (r_count == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                // ID/EXE still holds the finished divide; never restart here.
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the difference when it does not go negative.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (w_load) begin
            r_count   <= DIV_CNT_W'(DIV_CYCLES - 1);
            r_quo     <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (w_step) begin
            if (w_diff[32]) begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end else begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage: ALU, branch resolution, control-field gating and (optionally)
// the iterative unsigned divider.
//
// Build option: define EXE_DIV_EN to build the 32-cycle divider (div_iter).
// Without it DIV/REM return zero in one cycle and exe_stall is tied low.
//
// Ports:
//   clock, reset                       clock / async active-low reset
//   pc            in  [len-1:0]        PC+4 of the instruction in EXE
//   wb_en, mem_read, mem_write   in    control fields from ID/EXE
//   branch_type   in  [1:0]            NONE/BEZ/BNE/JMP
//   exe_cmd       in  [3:0]            ALU command (exe_pkg::exe_cmd_e)
//   alu_inp1, alu_inp2, reg2  in [31:0] operands (alu_inp2 = imm for branches)
//   dest          in  [4:0]            destination register
//   alu_result    out [31:0]           result to EXE/MEM
//   wb_en_out, mem_read_out, mem_write_out  out  gated control fields
//   reg2_out      out [31:0]           store data
//   dest_out      out [4:0]            destination register
//   br_taken      out                  redirect fetch / flush
//   br_addr       out [len-1:0]        branch target
//   exe_stall     out                  freeze PC, IF/ID and ID/EXE
// -----------------------------------------------------------------------------
module exe_stage
    import exe_pkg::*;
#(
    parameter int len = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [len-1:0] pc,
    input  logic           wb_en,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [1:0]     branch_type,
    input  logic [3:0]     exe_cmd,
    input  logic [31:0]    alu_inp1,
    input  logic [31:0]    alu_inp2,
    input  logic [31:0]    reg2,
    input  logic [4:0]     dest,
    output logic [31:0]    alu_result,
    output logic           wb_en_out,
    output logic           mem_read_out,
    output logic           mem_write_out,
    output logic [31:0]    reg2_out,
    output logic [4:0]     dest_out,
    output logic           br_taken,
    output logic [len-1:0] br_addr,
    output logic           exe_stall
);

    logic [4:0]  w_shamt;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic [31:0] w_alu;

    assign w_shamt = alu_inp2[4:0];

`ifdef EXE_DIV_EN
    logic        w_div_start;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_quotient;
    logic [31:0] w_remainder;

    assign w_div_start = ((exe_cmd == CMD_DIV) || (exe_cmd == CMD_REM)) && wb_en;

    div_iter u_div_iter (
        .clock       (clock),
        .reset       (reset),
        .i_start     (w_div_start),
        .i_dividend  (alu_inp1),
        .i_divisor   (alu_inp2),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_quotient),
        .o_remainder (w_remainder)
    );

    // Present divider results only in DONE so no partial value escapes.
    assign w_div_q   = w_div_done ? w_quotient  : '0;
    assign w_div_r   = w_div_done ? w_remainder : '0;
    assign exe_stall = w_div_busy;
`else
    assign w_div_q   = '0;
    assign w_div_r   = '0;
    assign exe_stall = 1'b0;
`endif

    always_comb begin
        w_alu = '0;
        case (exe_cmd)
            CMD_ADD: w_alu = alu_inp1 + alu_inp2;
            CMD_SUB: w_alu = alu_inp1 - alu_inp2;
            CMD_AND: w_alu = alu_inp1 & alu_inp2;
            CMD_OR:  w_alu = alu_inp1 | alu_inp2;
            CMD_NOR: w_alu = ~(alu_inp1 | alu_inp2);
            CMD_XOR: w_alu = alu_inp1 ^ alu_inp2;
            CMD_SLL: w_alu = alu_inp1 << w_shamt;
            CMD_SRL: w_alu = alu_inp1 >> w_shamt;
            CMD_SRA: w_alu = $signed(alu_inp1) >>> w_shamt;
            CMD_SLT: w_alu = {31'b0, ($signed(alu_inp1) < $signed(alu_inp2))};
            CMD_MUL: w_alu = alu_inp1 * alu_inp2;
            CMD_DIV: w_alu = w_div_q;
            CMD_REM: w_alu = w_div_r;
            default: w_alu = '0;
        endcase
    end

    assign alu_result = w_alu;

    // Branch target: word offset from the sign-extended immediate.
    assign br_addr  = pc + {alu_inp2[len-3:0], 2'b00};
    assign br_taken = ((branch_type == BR_BEZ) && (alu_inp1 == '0))
                    | ((branch_type == BR_BNE) && (alu_inp1 != reg2))
                    |  (branch_type == BR_JMP);

    assign wb_en_out     = wb_en     & ~exe_stall;
    assign mem_read_out  = mem_read  & ~exe_stall;
    assign mem_write_out = mem_write & ~exe_stall;
    assign reg2_out      = reg2;
    assign dest_out      = dest;

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
// Directed self-checking bench for exe_stage. Divider checks follow the
// EXE_DIV_EN build option; the disabled build checks the single-cycle zero
// result and the absence of stalls instead.
// -----------------------------------------------------------------------------
module tb_exe_stage;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic        wb_en;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  branch_type;
    logic [3:0]  exe_cmd;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [31:0] reg2;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        wb_en_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [31:0] reg2_out;
    logic [4:0]  dest_out;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        exe_stall;

    int n_checks;
    int n_fail;

    exe_stage #(.len(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (pc),
        .wb_en         (wb_en),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch_type   (branch_type),
        .exe_cmd       (exe_cmd),
        .alu_inp1      (alu_inp1),
        .alu_inp2      (alu_inp2),
        .reg2          (reg2),
        .dest          (dest),
        .alu_result    (alu_result),
        .wb_en_out     (wb_en_out),
        .mem_read_out  (mem_read_out),
        .mem_write_out (mem_write_out),
        .reg2_out      (reg2_out),
        .dest_out      (dest_out),
        .br_taken      (br_taken),
        .br_addr       (br_addr),
        .exe_stall     (exe_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        exe_cmd  = cmd;
        alu_inp1 = a;
        alu_inp2 = b;
        #1;
    endtask

    task automatic alu_check(input string tag, input logic [3:0] cmd,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        set_op(cmd, a, b);
        check(tag, alu_result, exp);
        check({tag, " no_stall"}, {31'b0, exe_stall}, 32'd0);
        tick();
    endtask

    task automatic br_check(input string tag, input logic [1:0] bt,
                            input logic [31:0] a, input logic [31:0] r2,
                            input logic [31:0] imm, input logic exp_taken,
                            input logic [31:0] exp_addr);
        branch_type = bt;
        reg2        = r2;
        set_op(4'hF, a, imm);
        check({tag, " taken"}, {31'b0, br_taken}, {31'b0, exp_taken});
        check({tag, " addr"}, br_addr, exp_addr);
        tick();
    endtask

`ifdef EXE_DIV_EN
    task automatic run_div(input string tag, input logic [3:0] cmd,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int n;
        logic gate_bad;
        wb_en     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        set_op(cmd, a, b);
        check({tag, " stall_at_entry"}, {31'b0, exe_stall}, 32'd1);
        n = 0;
        gate_bad = 1'b0;
        while (exe_stall === 1'b1 && n < 100) begin
            n++;
            if (wb_en_out !== 1'b0) gate_bad = 1'b1;
            tick();
        end
        check({tag, " stall_cycles"}, n, 32'd33);
        check({tag, " wb_gated"}, {31'b0, gate_bad}, 32'd0);
        check({tag, " result"}, alu_result, exp);
        check({tag, " wb_done"}, {31'b0, wb_en_out}, 32'd1);
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        pc          = '0;
        wb_en       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch_type = 2'd0;
        exe_cmd     = 4'h0;
        alu_inp1    = '0;
        alu_inp2    = '0;
        reg2        = '0;
        dest        = '0;

        #3;
        check("reset stall", {31'b0, exe_stall}, 32'd0);
        check("reset result", alu_result, 32'd0);
        check("reset br_taken", {31'b0, br_taken}, 32'd0);
        check("reset wb_en_out", {31'b0, wb_en_out}, 32'd0);
        #9 reset = 1'b1;
        tick();

        // Pass-through and ungated control fields
        wb_en = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
        reg2 = 32'hDEADBEEF; dest = 5'd17;
        #1;
        check("pass reg2", reg2_out, 32'hDEADBEEF);
        check("pass dest", {27'b0, dest_out}, 32'd17);
        check("pass wb", {31'b0, wb_en_out}, 32'd1);
        check("pass mem_read", {31'b0, mem_read_out}, 32'd1);
        check("pass mem_write", {31'b0, mem_write_out}, 32'd1);
        mem_read = 1'b0; mem_write = 1'b0; reg2 = '0;
        tick();

        // ALU sweep
        alu_check("ADD", 4'h0, 32'd7, 32'hFFFFFFFD, 32'd4);
        alu_check("SUB", 4'h1, 32'd0, 32'd1, 32'hFFFFFFFF);
        alu_check("AND", 4'h2, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F);
        alu_check("OR",  4'h3, 32'hF0000000, 32'h0000000F, 32'hF000000F);
        alu_check("NOR", 4'h4, 32'hF0000000, 32'h0000000F, 32'h0FFFFFF0);
        alu_check("XOR", 4'h5, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0);
        alu_check("SLL", 4'h6, 32'h00000003, 32'h00000024, 32'h00000030);
        alu_check("SRL", 4'h7, 32'h80000000, 32'd4, 32'h08000000);
        alu_check("SRA", 4'h8, 32'h80000000, 32'd4, 32'hF8000000);
        alu_check("SLT neg", 4'h9, 32'hFFFFFFFF, 32'd1, 32'd1);
        alu_check("SLT pos", 4'h9, 32'd1, 32'hFFFFFFFF, 32'd0);
        alu_check("MUL wrap", 4'hA, 32'h00010000, 32'h00010000, 32'd0);
        alu_check("MUL", 4'hA, 32'd1234, 32'd5678, 32'd7006652);
        alu_check("NOP", 4'hF, 32'd5, 32'd6, 32'd0);

        // Branches at pc=100
        wb_en = 1'b0;
        pc = 32'd100;
        br_check("BEZ zero", 2'd1, 32'd0, 32'd9, 32'd3, 1'b1, 32'd112);
        br_check("BEZ nonzero", 2'd1, 32'd4, 32'd9, 32'd3, 1'b0, 32'd112);
        br_check("BNE equal", 2'd2, 32'd9, 32'd9, 32'd2, 1'b0, 32'd108);
        br_check("BNE differ", 2'd2, 32'd8, 32'd9, 32'd2, 1'b1, 32'd108);
        br_check("JMP back", 2'd3, 32'd1, 32'd2, 32'hFFFFFFFF, 1'b1, 32'd96);
        br_check("NONE", 2'd0, 32'd0, 32'd0, 32'd1, 1'b0, 32'd104);
        branch_type = 2'd0;

`ifdef EXE_DIV_EN
        run_div("DIV 100/7", 4'hB, 32'd100, 32'd7, 32'd14);
        exe_cmd = 4'hF; wb_en = 1'b0; tick();
        run_div("REM 100/7", 4'hC, 32'd100, 32'd7, 32'd2);
        exe_cmd = 4'hF; wb_en = 1'b0; tick();
        run_div("DIV 5/0", 4'hB, 32'd5, 32'd0, 32'hFFFFFFFF);
        exe_cmd = 4'hF; wb_en = 1'b0; tick();
        run_div("REM 5/0", 4'hC, 32'd5, 32'd0, 32'd5);
        exe_cmd = 4'hF; wb_en = 1'b0; tick();

        // Back-to-back: REM enters EXE right after the DIV's DONE cycle
        run_div("B2B DIV", 4'hB, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF);
        tick();
        run_div("B2B REM", 4'hC, 32'd1000, 32'd33, 32'd10);
        exe_cmd = 4'hF; wb_en = 1'b0; tick();

        // Reset in BUSY cycle 10 aborts the divide at once
        wb_en = 1'b1;
        set_op(4'hB, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        check("pre-reset stall", {31'b0, exe_stall}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort stall", {31'b0, exe_stall}, 32'd0);
        check("abort result", alu_result, 32'd0);
        exe_cmd = 4'h0; alu_inp1 = '0; alu_inp2 = '0; wb_en = 1'b0;
        #2 reset = 1'b1;
        tick();
        run_div("post-reset REM", 4'hC, 32'd77, 32'd10, 32'd7);
        exe_cmd = 4'hF; wb_en = 1'b0; tick();
`else
        // Divider not built: zero result in a single cycle, never a stall
        wb_en = 1'b1;
        set_op(4'hB, 32'd100, 32'd7);
        check("nodiv DIV result", alu_result, 32'd0);
        check("nodiv DIV stall", {31'b0, exe_stall}, 32'd0);
        check("nodiv DIV wb", {31'b0, wb_en_out}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nodiv stall later", {31'b0, exe_stall}, 32'd0);
        end
        set_op(4'hC, 32'd100, 32'd7);
        check("nodiv REM result", alu_result, 32'd0);
        check("nodiv REM stall", {31'b0, exe_stall}, 32'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
